// File: rtl/csr_fetch_sequencer.sv
// CSR sparse-matrix walker: fetches row pointers, column indices, values and vector elements,
// and queues (value, vector, last) triples. Optional pointer check under `CSR_PTR_CHECK_EN`.
module csr_fetch_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [15:0]       n_rows,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [ADDR_W-1:0] col_base,
    input  logic [ADDR_W-1:0] val_base,
    input  logic [ADDR_W-1:0] vec_base,
    output logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              busy,
    output logic              done,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [DATA_W-1:0] pair_val,
    output logic [DATA_W-1:0] pair_vec,
    output logic              pair_last,
    output logic              err
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StRp0, StRpn, StCol, StVec, StEmpty, StDrain, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] k_q, k_d, end_q, end_d, col_q, col_d, val_q, val_d;
    logic [15:0]       r_q, r_d, n_rows_q, n_rows_d, r_next;
    logic [ADDR_W-1:0] row_base_q, col_base_q, val_base_q, vec_base_q;
    logic              err_q, err_d, sample;

    logic [DATA_W-1:0] fifo_val [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_vec [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              full, pop, can_push, push, push_last, last_nz;
    logic [DATA_W-1:0] push_val, push_vec;
    state_e            row_exit;

    assign pair_valid = (cnt_q != '0);
    assign full       = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = pair_valid & pair_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign can_push   = ~full | pop;
    assign r_next     = r_q + 16'd1;
    assign row_exit   = (r_next == n_rows_q) ? StDrain : StRpn;
    assign last_nz    = (k_q + DATA_W'(1) == end_q);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        end_d     = end_q;
        col_d     = col_q;
        val_d     = val_q;
        r_d       = r_q;
        n_rows_d  = n_rows_q;
        err_d     = err_q;
        sample    = 1'b0;
        addr_a    = '0;
        addr_b    = '0;
        push      = 1'b0;
        push_val  = '0;
        push_vec  = '0;
        push_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sample   = 1'b1;
                    n_rows_d = n_rows;
                    err_d    = 1'b0;
                    state_d  = (n_rows == 16'd0) ? StDone : StRp0;
                end
            end
            StRp0: begin
                addr_a  = row_base_q;
                k_d     = data_a;
                r_d     = 16'd0;
                state_d = StRpn;
            end
            StRpn: begin
                addr_a = row_base_q + ADDR_W'(r_q) + ADDR_W'(1);
                end_d  = data_a;
`ifdef CSR_PTR_CHECK_EN
                if (data_a < k_q) begin
                    err_d   = 1'b1;
                    state_d = StDrain;
                end else
`endif
                if (data_a <= k_q) state_d = StEmpty;
                else               state_d = StCol;
            end
            StCol: begin
                addr_a  = col_base_q + ADDR_W'(k_q);
                addr_b  = val_base_q + ADDR_W'(k_q);
                col_d   = data_a;
                val_d   = data_b;
                state_d = StVec;
            end
            StVec: begin
                addr_b = vec_base_q + ADDR_W'(col_q);
                if (can_push) begin
                    push      = 1'b1;
                    push_val  = val_q;
                    push_vec  = data_b;
                    push_last = last_nz;
                    k_d       = k_q + DATA_W'(1);
                    if (last_nz) begin
                        r_d     = r_next;
                        state_d = row_exit;
                    end else begin
                        state_d = StCol;
                    end
                end
            end
            StEmpty: begin
                if (can_push) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    r_d       = r_next;
                    state_d   = row_exit;
                end
            end
            StDrain: begin
                // Leave as soon as the last entry is being popped.
                if (cnt_q == '0 || (cnt_q == (PTR_W+1)'(1) && pop)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            end_q      <= '0;
            col_q      <= '0;
            val_q      <= '0;
            r_q        <= '0;
            n_rows_q   <= '0;
            err_q      <= 1'b0;
            row_base_q <= '0;
            col_base_q <= '0;
            val_base_q <= '0;
            vec_base_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            end_q    <= end_d;
            col_q    <= col_d;
            val_q    <= val_d;
            r_q      <= r_d;
            n_rows_q <= n_rows_d;
            err_q    <= err_d;
            if (sample) begin
                row_base_q <= row_base;
                col_base_q <= col_base;
                val_base_q <= val_base;
                vec_base_q <= vec_base;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_val[wr_ptr_q]  <= push_val;
            fifo_vec[wr_ptr_q]  <= push_vec;
            fifo_last[wr_ptr_q] <= push_last;
        end
    end

    assign pair_val  = pair_valid ? fifo_val[rd_ptr_q] : '0;
    assign pair_vec  = pair_valid ? fifo_vec[rd_ptr_q] : '0;
    assign pair_last = pair_valid & fifo_last[rd_ptr_q];
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = err_q;

endmodule

// File: tb/tb_csr_fetch_sequencer.sv
// Bench for csr_fetch_sequencer: a memory image, a row-by-row reference walk of the CSR arrays
// and a per-cycle checker of the output stream, plus directed scenarios.
module tb_csr_fetch_sequencer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_rows = '0;
    logic [31:0] row_base = '0, col_base = '0, val_base = '0, vec_base = '0;
    logic [31:0] addr_a, data_a, addr_b, data_b;
    logic        busy, done, pair_valid, pair_last, err;
    logic        pair_ready = 1'b1;
    logic [31:0] pair_val, pair_vec;

    logic [31:0] mem [512];

    typedef struct {
        logic [31:0] v;
        logic [31:0] x;
        logic        l;
    } ent_t;

    ent_t exp_q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, done_seen = 0, last_pop_cyc = 0, jobs_done = 0;
    bit   last_pop_valid = 0, exp_err = 0;

    csr_fetch_sequencer dut (
        .Clk(Clk), .Rst(Rst), .start(start), .n_rows(n_rows),
        .row_base(row_base), .col_base(col_base), .val_base(val_base), .vec_base(vec_base),
        .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b),
        .busy(busy), .done(done), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_val(pair_val), .pair_vec(pair_vec), .pair_last(pair_last), .err(err)
    );

    initial forever #5 Clk = ~Clk;

    assign data_a = (addr_a < 32'd512) ? mem[addr_a[8:0]] : '0;
    assign data_b = (addr_b < 32'd512) ? mem[addr_b[8:0]] : '0;

    function automatic int rd(input int a);
        return (a >= 0 && a < 512) ? int'(mem[a]) : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference walk over the CSR arrays, one row at a time.
    task automatic build_exp(input int rb, input int cb, input int vb, input int xb, input int n);
        int k, e;
        exp_err = 0;
        k = rd(rb);
        for (int r = 0; r < n; r++) begin
            e = rd(rb + r + 1);
`ifdef CSR_PTR_CHECK_EN
            if (e < k) begin
                exp_err = 1;
                break;
            end
`endif
            if (e <= k) exp_q.push_back('{32'd0, 32'd0, 1'b1});
            else begin
                for (; k < e; k++)
                    exp_q.push_back('{mem[vb + k], mem[xb + rd(cb + k)], (k == e - 1)});
            end
        end
    endtask

    task automatic launch(input int rb, input int n);
        build_exp(rb, 200, 300, 400, n);
        @(posedge Clk); #1;
        row_base = rb; col_base = 200; val_base = 300; vec_base = 400;
        n_rows = n[15:0];
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0, i;
        d0 = done_seen;
        i = 0;
        while (done_seen == d0 && i < 400) begin
            @(posedge Clk);
            i++;
        end
        check({name, "_done_seen"}, done_seen - d0, 1);
        if (done_seen != d0) jobs_done++;
        #1;
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_err"}, err, exp_err);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int lv[4] = '{5, 7, 0, 9};
        int lx[4] = '{20, 10, 0, 30};
        int ll[4] = '{0, 1, 1, 1};
        int d0;
        bit found;

        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[100] = 0; mem[101] = 2; mem[102] = 2; mem[103] = 3;
        mem[120] = 0; mem[121] = 3; mem[122] = 6;
        mem[150] = 3; mem[151] = 1;
        mem[200] = 1; mem[201] = 0; mem[202] = 2; mem[203] = 2; mem[204] = 1; mem[205] = 0;
        mem[300] = 5; mem[301] = 7; mem[302] = 9; mem[303] = 11; mem[304] = 13; mem[305] = 15;
        mem[400] = 10; mem[401] = 20; mem[402] = 30;

        fork
            forever begin
                @(posedge Clk);
                cyc++;
            end
            forever begin
                @(negedge Clk);
                if (Rst) begin
                    last_pop_valid = 0;
                end else begin
                    if (pair_valid && pair_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_entry", 1, 0);
                        end else begin
                            ent_t e;
                            e = exp_q.pop_front();
                            check("pair_val", pair_val, e.v);
                            check("pair_vec", pair_vec, e.x);
                            check("pair_last", pair_last, e.l);
                        end
                        last_pop_cyc = cyc;
                        last_pop_valid = 1;
                    end
                    if (done) begin
                        done_seen++;
                        if (last_pop_valid) check("done_after_pop", cyc, last_pop_cyc + 1);
                        last_pop_valid = 0;
                    end
                end
            end
        join_none

        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", pair_valid, 0);
        check("rst_err", err, 0);
        check("rst_val", pair_val, 0);
        check("rst_vec", pair_vec, 0);
        check("rst_last", pair_last, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_addr_b", addr_b, 0);

        // Common job: pin the reference stream, then first-entry latency.
        launch(100, 3);
        check("model_len", exp_q.size(), 4);
        for (int i = 0; i < exp_q.size() && i < 4; i++) begin
            check("model_val", exp_q[i].v, lv[i]);
            check("model_vec", exp_q[i].x, lx[i]);
            check("model_last", exp_q[i].l, ll[i]);
        end
        for (int e = 1; e <= 4; e++) begin
            @(posedge Clk); #1;
            check($sformatf("first_valid_edge%0d", e), pair_valid, (e == 4));
        end
        wait_done("common");

        // Back-pressure on the common job.
        pair_ready = 1'b0;
        launch(100, 3);
        repeat (20) @(posedge Clk);
        #1;
        check("stall_valid", pair_valid, 1);
        check("stall_busy", busy, 1);
        pair_ready = 1'b1;
        wait_done("stall");

        // Six nonzeros against a four-entry FIFO: VEC must hold on k=4 (col 1 -> 401).
        pair_ready = 1'b0;
        launch(120, 2);
        repeat (20) @(posedge Clk);
        #1;
        check("hold_addr_b", addr_b, 401);
        check("hold_addr_a", addr_a, 0);
        check("hold_busy", busy, 1);
        @(posedge Clk); #1;
        check("hold_addr_b_stable", addr_b, 401);
        check("hold_head_val", pair_val, 5);
        pair_ready = 1'b1;
        wait_done("long");

        // Decreasing row pointer.
        launch(150, 1);
        wait_done("badptr");

        // Zero rows.
        d0 = done_seen;
        launch(100, 0);
        check("n0_done", done, 1);
        check("n0_addr_a", addr_a, 0);
        check("n0_addr_b", addr_b, 0);
        check("n0_valid", pair_valid, 0);
        @(posedge Clk); #1;
        check("n0_done_clear", done, 0);
        check("n0_busy", busy, 0);
        check("n0_valid2", pair_valid, 0);
        check("n0_err", err, 0);
        check("n0_done_count", done_seen - d0, 1);
        jobs_done++;

        // Reset in the middle of a job (COL for k=1 reads addr_a=201).
        launch(100, 3);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge Clk);
            if (addr_a == 32'd201) found = 1;
        end
        check("rst_point_found", found, 1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_valid", pair_valid, 0);
        check("abort_done", done, 0);
        d0 = done_seen;
        repeat (10) @(posedge Clk);
        check("abort_no_done", done_seen - d0, 0);
        launch(100, 3);
        wait_done("rerun");

        // Start while busy must be ignored.
        d0 = done_seen;
        launch(100, 3);
        repeat (6) @(posedge Clk);
        #1;
        row_base = 0; n_rows = 0; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        repeat (5) @(posedge Clk);
        check("busy_start_done_count", done_seen - d0, 1);

        check("total_done", done_seen, jobs_done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
